// File: rtl/edf_label_stamper.sv
// edf_label_stamper
//  Write-side front end for the heap-based priority label FIFO.
//  Each accepted payload is stamped with an absolute EDF deadline label
//  (current epoch + relative deadline, clamped to LMAX). The result goes
//  out as a single fifo_we pulse. Writes are paced so they never overlap
//  a reader pop or the heap's sift-up.
//  Optional feature macro: LABEL_SAT_CNT_EN. When it is defined, sat_cnt
//  counts accepts whose label had to be clamped. Otherwise sat_cnt is
//  tied to zero.
module edf_label_stamper #(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 16,
   parameter int LABEL_WIDTH = 8,
   parameter int TICK_SHIFT  = 4,
   parameter int GAP_CYCLES  = ADDR_WIDTH + 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH-LABEL_WIDTH-1:0] in_payload,
   input  logic [LABEL_WIDTH-1:0]            in_rel_dl,
   output logic                              fifo_we,
   output logic [DATA_WIDTH-1:0]             fifo_din,
   input  logic                              fifo_re,
   input  logic                              fifo_full,
   input  logic                              fifo_empty,
   output logic [LABEL_WIDTH-1:0]            epoch,
   output logic [15:0]                       sat_cnt
);

   localparam int PW = DATA_WIDTH - LABEL_WIDTH;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   // All-ones label marks an empty heap slot, so the largest usable label is one below it.
   localparam logic [LABEL_WIDTH-1:0] LMAX      = {{(LABEL_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [LABEL_WIDTH-1:0] EPOCH_ONE = LABEL_WIDTH'(1);
   localparam logic [TICK_SHIFT-1:0]  PRE_MAX   = {TICK_SHIFT{1'b1}};
   localparam logic [TICK_SHIFT-1:0]  PRE_ONE   = TICK_SHIFT'(1);
   localparam logic [GW-1:0]          GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0]          GAP_ONE   = GW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [TICK_SHIFT-1:0]   pre_q, pre_d;
   logic [LABEL_WIDTH-1:0]  epoch_q, epoch_d;
   logic [LABEL_WIDTH-1:0]  label_q, label_d;
   logic [PW-1:0]           payload_q, payload_d;
   logic [DATA_WIDTH-1:0]   last_q, last_d;
   logic [GW-1:0]           gap_q, gap_d;

   logic                    accept_s;
   logic                    write_s;
   logic                    over_s;
   logic [LABEL_WIDTH:0]    sum_s;

   // Deadline sum is one bit wider so an overflow past LMAX is caught rather than wrapped.
   assign sum_s    = {1'b0, epoch_q} + {1'b0, in_rel_dl};
   assign over_s   = (sum_s > {1'b0, LMAX});
   assign in_ready = rst_n && (state_q == IDLE) && !fifo_full;
   assign accept_s = in_valid && in_ready;
   // The write must see this cycle's fifo_re and fifo_full, so the strobe cannot come from a flop.
   assign write_s  = (state_q == ISSUE) && !fifo_full && !fifo_re;
   assign fifo_we  = write_s;
   // Present the pending word while issuing. At all other times hold the last word written.
   assign fifo_din = (state_q == ISSUE) ? {label_q, payload_q} : last_q;
   assign epoch    = epoch_q;

   // Next-state logic for the IDLE -> ISSUE -> SETTLE pacing FSM and its entry latch.
   always_comb begin
      state_d   = state_q;
      label_d   = label_q;
      payload_d = payload_q;
      last_d    = last_q;
      gap_d     = gap_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               label_d   = over_s ? LMAX : sum_s[LABEL_WIDTH-1:0];
               payload_d = in_payload;
               state_d   = ISSUE;
            end else begin
               state_d   = IDLE;
            end
         end
         ISSUE: begin
            if (write_s) begin
               last_d  = {label_q, payload_q};
               gap_d   = '0;
               state_d = SETTLE;
            end else begin
               state_d = ISSUE;
            end
         end
         SETTLE: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d   = gap_q + GAP_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Epoch prescaler. An empty FIFO seen while idle restarts the time base at zero.
   always_comb begin
      pre_d   = pre_q;
      epoch_d = epoch_q;
      if (fifo_empty && (state_q == IDLE)) begin
         pre_d   = '0;
         epoch_d = '0;
      end else begin
         pre_d = pre_q + PRE_ONE;
         if (pre_q == PRE_MAX) begin
            epoch_d = (epoch_q == LMAX) ? LMAX : (epoch_q + EPOCH_ONE);
         end else begin
            epoch_d = epoch_q;
         end
      end
   end

   // State, entry, and time-base registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         epoch_q   <= '0;
         label_q   <= '0;
         payload_q <= '0;
         last_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         epoch_q   <= epoch_d;
         label_q   <= label_d;
         payload_q <= payload_d;
         last_q    <= last_d;
         gap_q     <= gap_d;
      end
   end

`ifdef LABEL_SAT_CNT_EN
   logic [15:0] sat_q, sat_d;

   // Count accepts whose label had to be clamped. The count holds at all-ones.
   always_comb begin
      sat_d = sat_q;
      if (accept_s && over_s && (sat_q != 16'hFFFF)) begin
         sat_d = sat_q + 16'd1;
      end else begin
         sat_d = sat_q;
      end
   end

   // Clamp-counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 16'h0000;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign sat_cnt = sat_q;
`else
   assign sat_cnt = 16'h0000;
`endif

endmodule
